// File: rtl/button_filter_pkg.sv
// rtl/button_filter_pkg.sv - shared constants and helpers for the key input filter
package button_filter_pkg;

  localparam int BTN_CLK_DIV    = 50000;
  localparam int BTN_STABLE_CNT = 8;

  // Small values that keep simulation runs short.
  localparam int SIM_CLK_DIV    = 4;
  localparam int SIM_STABLE_CNT = 3;

  // A counter over 0..n-1 needs $clog2(n) bits, but never fewer than one.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_filter_if.sv
// rtl/button_filter_if.sv - raw key input and filtered level/change outputs
interface button_filter_if;
  logic btn_raw;
  logic btn_level;
  logic changed;

  modport master (output btn_raw, input btn_level, input changed);
  modport slave  (input btn_raw, output btn_level, output changed);
endinterface

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running prescaler, one-cycle tick every CLK_DIV clocks
module tick_gen
  import button_filter_pkg::*;
#(
  parameter int CLK_DIV = BTN_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int             W    = cnt_width(CLK_DIV);
  localparam logic [W-1:0]   LAST = W'(CLK_DIV - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/button_filter.sv
// rtl/button_filter.sv - synchronise, tick-sample and qualify a bouncy key input
module button_filter
  import button_filter_pkg::*;
#(
  parameter int CLK_DIV    = BTN_CLK_DIV,
  parameter int STABLE_CNT = BTN_STABLE_CNT,
  parameter int ACTIVE_LOW = 1
) (
  input logic            clk,
  input logic            reset,
  button_filter_if.slave bus
);

  localparam int           SW       = cnt_width(STABLE_CNT);
  localparam logic [SW-1:0] CNT_LAST = SW'(STABLE_CNT - 1);
  localparam logic         POLARITY = (ACTIVE_LOW != 0);

  logic          in_bit;
  logic          sync_q1;
  logic          sync_q2;
  logic          tick;
  logic          level_q;
  logic          changed_q;
  logic [SW-1:0] stable_cnt;

  assign in_bit = bus.btn_raw ^ POLARITY;

  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= in_bit;
      sync_q2 <= sync_q1;
    end
  end

  // Any tick sample that agrees with the current level cancels progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q    <= 1'b0;
      changed_q  <= 1'b0;
      stable_cnt <= '0;
    end else begin
      changed_q <= 1'b0;
      if (tick) begin
        if (sync_q2 == level_q) begin
          stable_cnt <= '0;
        end else if (stable_cnt == CNT_LAST) begin
          level_q    <= sync_q2;
          stable_cnt <= '0;
          changed_q  <= 1'b1;
        end else begin
          stable_cnt <= stable_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.btn_level = level_q;
  assign bus.changed   = changed_q;

endmodule

// File: tb/tb_button_filter.sv
// tb/tb_button_filter.sv - directed vector bench for button_filter
module tb_button_filter;
  import button_filter_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  button_filter_if bus ();

  button_filter #(
    .CLK_DIV    (SIM_CLK_DIV),
    .STABLE_CNT (SIM_STABLE_CNT),
    .ACTIVE_LOW (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    press;      // cycle btn_raw goes low, -1 never
    int    rel;        // cycle btn_raw returns high and stays, -1 never
    int    bounce_end; // toggle every 3 cycles from press until here, 0 none
    bit    glitch;     // 2-cycle low pulse every 20 cycles
    int    run_len;
    int    rise_lo, rise_hi;
    int    fall_lo, fall_hi;
    int    pulses;
    bit    final_lvl;
  } vec_t;

  vec_t vecs[5];

  function automatic bit raw_at(input vec_t v, input int c);
    if (v.glitch) return !((c % 20 == 13) || (c % 20 == 14));
    if (v.press < 0 || c < v.press) return 1'b1;
    if (v.bounce_end > 0 && c < v.bounce_end) return (((c - v.press) / 3) % 2) != 0;
    if (v.rel >= 0 && c >= v.rel) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string name, input bit ok, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic check_win(input string name, input int act, input int lo, input int hi);
    checks++;
    if (lo < 0 ? (act >= 0) : (act < lo || act > hi)) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Leaves reset released at a negedge; the next posedge is cycle 1.
  task automatic apply_reset(input string name);
    bus.btn_raw = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check({name, "_rst_level"}, bus.btn_level == 1'b0, int'(bus.btn_level), 0);
    check({name, "_rst_changed"}, bus.changed == 1'b0, int'(bus.changed), 0);
    check({name, "_rst_cnt"}, dut.stable_cnt == '0, int'(dut.stable_cnt), 0);
    reset = 1'b0;
  endtask

  initial begin
    int rise, fall, pulses, bad, over;
    bit lvl, chg, prev;
    int pre_cnt;

    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.btn_raw = 1'b1;

    vecs[0] = '{"hold_idle", -1, -1, 0, 1'b0, 100, -1, -1, -1, -1, 0, 1'b0};
    vecs[1] = '{"press",     20, -1, 0, 1'b0,  60, 31, 35, -1, -1, 1, 1'b1};
    vecs[2] = '{"bounce",    20, -1, 38, 1'b0, 80, 49, 53, -1, -1, 1, 1'b1};
    vecs[3] = '{"release",   20, 60, 0, 1'b0, 100, 31, 35, 71, 75, 2, 1'b0};
    vecs[4] = '{"glitch",    -1, -1, 0, 1'b1, 100, -1, -1, -1, -1, 0, 1'b0};

    foreach (vecs[i]) begin
      apply_reset(vecs[i].name);
      rise = -1; fall = -1; pulses = 0; bad = 0; over = 0; prev = 1'b0;
      for (int c = 0; c < vecs[i].run_len; c++) begin
        bus.btn_raw = raw_at(vecs[i], c);
        @(posedge clk);
        @(negedge clk);
        lvl = bus.btn_level;
        chg = bus.changed;
        if (chg) pulses++;
        if (chg != (lvl != prev)) bad++;
        if (lvl && !prev && rise < 0) rise = c + 1;
        if (!lvl && prev && fall < 0) fall = c + 1;
        if (int'(dut.stable_cnt) > SIM_STABLE_CNT - 1) over++;
        prev = lvl;
      end
      check_win({vecs[i].name, "_rise"}, rise, vecs[i].rise_lo, vecs[i].rise_hi);
      check_win({vecs[i].name, "_fall"}, fall, vecs[i].fall_lo, vecs[i].fall_hi);
      check({vecs[i].name, "_pulses"}, pulses == vecs[i].pulses, pulses, vecs[i].pulses);
      check({vecs[i].name, "_final"}, prev == vecs[i].final_lvl, int'(prev), int'(vecs[i].final_lvl));
      check({vecs[i].name, "_changed_align"}, bad == 0, bad, 0);
      check({vecs[i].name, "_cnt_bound"}, over == 0, over, 0);
    end

    // Reset pulsed while the press is two ticks into qualification.
    apply_reset("midreset");
    for (int c = 0; c < 28; c++) begin
      bus.btn_raw = (c < 20);
      @(posedge clk);
      @(negedge clk);
    end
    pre_cnt = int'(dut.stable_cnt);
    check("midreset_progress", pre_cnt == 2, pre_cnt, 2);
    bus.btn_raw = 1'b0;
    reset = 1'b1;
    #1;
    check("midreset_level", bus.btn_level == 1'b0, int'(bus.btn_level), 0);
    check("midreset_cnt", dut.stable_cnt == '0, int'(dut.stable_cnt), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    rise = -1; pulses = 0; prev = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      @(negedge clk);
      lvl = bus.btn_level;
      if (bus.changed) pulses++;
      if (lvl && !prev && rise < 0) rise = c + 1;
      prev = lvl;
    end
    check_win("midreset_rise", rise, 11, 15);
    check("midreset_pulses", pulses == 1, pulses, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
